// File: rtl/toi2s_pkg.sv
// Shared types and constants for the toi2s amplifier control path.
//
// Contents:
//   amp_seq_state_t   - amplifier sequencer state. The encoding is visible to
//                       software through state_mon, so it must not be reordered.
//   amp_init_entry_t  - one register write of the amplifier init table.
//   AMP_INIT_TABLE    - init writes, issued in order from entry 0. A sequencer
//                       built with NUM_INIT = N uses the first N entries.
//   rb_sys_cfg_wire_t - amplifier-related fields of the sys_cfg register.
package toi2s_pkg;

    typedef enum logic [2:0] {
        AMP_OFF         = 3'd0,
        AMP_PWRUP       = 3'd1,
        AMP_INIT_WR     = 3'd2,
        AMP_READY       = 3'd3,
        AMP_UNMUTE_WAIT = 3'd4,
        AMP_PLAY        = 3'd5,
        AMP_SHUTDOWN    = 3'd6,
        AMP_FAULT       = 3'd7
    } amp_seq_state_t;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } amp_init_entry_t;

    localparam int AMP_INIT_MAX = 16;

    // Unused tail entries are all-zero and are never issued for NUM_INIT < 16.
    localparam amp_init_entry_t AMP_INIT_TABLE [AMP_INIT_MAX] = '{
        '{reg_addr: 8'h01, data: 8'h80},   // soft reset
        '{reg_addr: 8'h02, data: 8'h10},   // I2S format
        '{reg_addr: 8'h03, data: 8'h24},   // analog gain
        '{reg_addr: 8'h04, data: 8'h0F},   // output stage enable
        '{reg_addr: 8'h00, data: 8'h00},
        '{reg_addr: 8'h00, data: 8'h00},
        '{reg_addr: 8'h00, data: 8'h00},
        '{reg_addr: 8'h00, data: 8'h00},
        '{reg_addr: 8'h00, data: 8'h00},
        '{reg_addr: 8'h00, data: 8'h00},
        '{reg_addr: 8'h00, data: 8'h00},
        '{reg_addr: 8'h00, data: 8'h00},
        '{reg_addr: 8'h00, data: 8'h00},
        '{reg_addr: 8'h00, data: 8'h00},
        '{reg_addr: 8'h00, data: 8'h00},
        '{reg_addr: 8'h00, data: 8'h00}
    };

    typedef struct packed {
        logic           amp_en;
        logic           soft_mute;
        logic           amp_err;
        amp_seq_state_t amp_state;
    } rb_sys_cfg_wire_t;

endpackage

// File: rtl/amp_seq_ctrl.sv
// Power/mute sequencer for the external I2S amplifier.
//
// Owns amp_nenable and amp_mute. It powers the amplifier up and waits for it
// to settle, issues the init table through the byte-level I2C master, then
// unmutes once the audio stream has been valid long enough. On disable it
// mutes first and removes power only after the mute has settled.
//
// Ports:
//   clk, resetb           system clock, asynchronous active-low reset
//   amp_en_cfg            sys_cfg amplifier enable (level)
//   soft_mute_cfg         sys_cfg soft mute (level)
//   audio_valid           SPDIF lock / I2S stream valid
//   m_req                 write request to the I2C master
//   m_dev_addr            7-bit device address (constant DEV_ADDR)
//   m_reg_addr, m_wdata   register address and data of the current write
//   m_ack, m_nack         1-cycle completion pulses from the I2C master
//   amp_nenable           amplifier enable, active low
//   amp_mute              amplifier mute, active high
//   err_flag              sticky init failure, cleared on the next power-up
//   state_mon             current amp_seq_state_t encoding
//
// Master handshake: m_req rises with m_reg_addr/m_wdata already valid, and
// all three hold until the cycle after the master returns m_ack or m_nack.
// A completion pulse is only honoured while m_req is high. m_ack and m_nack
// together count as a NACK. After each completion m_req stays low for at
// least one cycle. An asynchronous reset may withdraw m_req at any time.
module amp_seq_ctrl
    import toi2s_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR     = 7'h4C,
    parameter int          NUM_INIT     = 4,
    parameter int          T_PWRUP_CYC  = 27000,
    parameter int          T_UNMUTE_CYC = 270000,
    parameter int          T_MUTE_CYC   = 27000,
    parameter int          MAX_RETRY    = 2
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       amp_en_cfg,
    input  logic       soft_mute_cfg,
    input  logic       audio_valid,
    output logic       m_req,
    output logic [6:0] m_dev_addr,
    output logic [7:0] m_reg_addr,
    output logic [7:0] m_wdata,
    input  logic       m_ack,
    input  logic       m_nack,
    output logic       amp_nenable,
    output logic       amp_mute,
    output logic       err_flag,
    output logic [2:0] state_mon
);

    localparam int T_MAX_A = (T_PWRUP_CYC > T_MUTE_CYC) ? T_PWRUP_CYC : T_MUTE_CYC;
    localparam int T_MAX   = (T_UNMUTE_CYC > T_MAX_A) ? T_UNMUTE_CYC : T_MAX_A;
    localparam int CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int IDX_W   = 4;

    // Counters load N-1 and act when they read 0, so every wait is N cycles.
    localparam logic [CNT_W-1:0]   PWRUP_LOAD  = CNT_W'(T_PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0]   UNMUTE_LOAD = CNT_W'(T_UNMUTE_CYC - 1);
    localparam logic [CNT_W-1:0]   MUTE_LOAD   = CNT_W'(T_MUTE_CYC - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_INIT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM   = RETRY_W'(MAX_RETRY);

    amp_seq_state_t     state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               req_q, req_d;
    logic [7:0]         reg_addr_q, reg_addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               nenable_q, nenable_d;
    logic               mute_q, mute_d;
    logic               err_q, err_d;
    // Set once amp_en_cfg has been seen low during init; the write in flight
    // completes, but nothing further is issued.
    logic               abort_q, abort_d;

    logic            quit;
    amp_init_entry_t entry_cur;

    assign quit      = abort_q | ~amp_en_cfg;
    assign entry_cur = AMP_INIT_TABLE[idx_q];

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q    <= AMP_OFF;
            cnt_q      <= '0;
            idx_q      <= '0;
            retry_q    <= '0;
            req_q      <= 1'b0;
            reg_addr_q <= 8'h00;
            wdata_q    <= 8'h00;
            nenable_q  <= 1'b1;
            mute_q     <= 1'b1;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            req_q      <= req_d;
            reg_addr_q <= reg_addr_d;
            wdata_q    <= wdata_d;
            nenable_q  <= nenable_d;
            mute_q     <= mute_d;
            err_q      <= err_d;
            abort_q    <= abort_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        retry_d    = retry_q;
        req_d      = req_q;
        reg_addr_d = reg_addr_q;
        wdata_d    = wdata_q;
        nenable_d  = nenable_q;
        mute_d     = mute_q;
        err_d      = err_q;
        abort_d    = 1'b0;

        case (state_q)
            AMP_OFF: begin
                if (amp_en_cfg) begin
                    state_d   = AMP_PWRUP;
                    cnt_d     = PWRUP_LOAD;
                    nenable_d = 1'b0;
                    err_d     = 1'b0;
                end
            end

            AMP_PWRUP: begin
                if (!amp_en_cfg) begin
                    state_d = AMP_SHUTDOWN;
                    cnt_d   = MUTE_LOAD;
                    mute_d  = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d    = AMP_INIT_WR;
                    idx_d      = '0;
                    retry_d    = '0;
                    req_d      = 1'b1;
                    reg_addr_d = AMP_INIT_TABLE[0].reg_addr;
                    wdata_d    = AMP_INIT_TABLE[0].data;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            AMP_INIT_WR: begin
                abort_d = quit;
                if (req_q) begin
                    if (m_nack) begin
                        // A simultaneous m_ack lands here too.
                        req_d = 1'b0;
                        if (retry_q < RETRY_LIM) begin
                            retry_d = retry_q + 1'b1;
                            if (quit) begin
                                state_d = AMP_SHUTDOWN;
                                cnt_d   = MUTE_LOAD;
                            end
                        end else begin
                            state_d   = AMP_FAULT;
                            err_d     = 1'b1;
                            nenable_d = 1'b1;
                        end
                    end else if (m_ack) begin
                        req_d = 1'b0;
                        if (quit) begin
                            state_d = AMP_SHUTDOWN;
                            cnt_d   = MUTE_LOAD;
                        end else if (idx_q == LAST_IDX) begin
                            state_d = AMP_READY;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            retry_d = '0;
                        end
                    end
                end else begin
                    // Idle gap after a completion: issue the next write or stop.
                    if (quit) begin
                        state_d = AMP_SHUTDOWN;
                        cnt_d   = MUTE_LOAD;
                    end else begin
                        req_d      = 1'b1;
                        reg_addr_d = entry_cur.reg_addr;
                        wdata_d    = entry_cur.data;
                    end
                end
            end

            AMP_READY: begin
                if (!amp_en_cfg) begin
                    state_d = AMP_SHUTDOWN;
                    cnt_d   = MUTE_LOAD;
                end else if (audio_valid && !soft_mute_cfg) begin
                    state_d = AMP_UNMUTE_WAIT;
                    cnt_d   = UNMUTE_LOAD;
                end
            end

            AMP_UNMUTE_WAIT: begin
                if (!amp_en_cfg) begin
                    state_d = AMP_SHUTDOWN;
                    cnt_d   = MUTE_LOAD;
                end else if (!audio_valid || soft_mute_cfg) begin
                    state_d = AMP_READY;
                end else if (cnt_q == '0) begin
                    state_d = AMP_PLAY;
                    mute_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            AMP_PLAY: begin
                if (!amp_en_cfg) begin
                    state_d = AMP_SHUTDOWN;
                    cnt_d   = MUTE_LOAD;
                    mute_d  = 1'b1;
                end else if (!audio_valid || soft_mute_cfg) begin
                    state_d = AMP_READY;
                    mute_d  = 1'b1;
                end
            end

            AMP_SHUTDOWN: begin
                // Re-enable is deliberately ignored until power is fully off.
                if (cnt_q == '0) begin
                    state_d   = AMP_OFF;
                    nenable_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            AMP_FAULT: begin
                if (!amp_en_cfg) begin
                    state_d = AMP_OFF;
                end
            end

            default: begin
                state_d   = AMP_OFF;
                req_d     = 1'b0;
                nenable_d = 1'b1;
                mute_d    = 1'b1;
            end
        endcase
    end

    assign m_req       = req_q;
    assign m_dev_addr  = DEV_ADDR;
    assign m_reg_addr  = reg_addr_q;
    assign m_wdata     = wdata_q;
    assign amp_nenable = nenable_q;
    assign amp_mute    = mute_q;
    assign err_flag    = err_q;
    assign state_mon   = state_q;

endmodule

// File: doc/amp_seq_ctrl.md
Name: amp_seq_ctrl

Overview:
Sequencer for the external I2S amplifier. It owns the amp_nenable and amp_mute pins and performs pop-free power-up, init and shutdown. During init it issues a fixed table of register writes through a byte-level request/ack interface to the amplifier I2C master. It sits between the register bank (sys_cfg enable/mute bits), the SPDIF/I2S stream-valid status and the amp I2C master.

Parameters:
DEV_ADDR, 7'h4C, amplifier 7-bit I2C device address
NUM_INIT, 4, number of entries in the init table (1..16)
T_PWRUP_CYC, 27000, cycles from amp_nenable low to first init write
T_UNMUTE_CYC, 270000, cycles audio_valid must stay high before unmute
T_MUTE_CYC, 27000, cycles muted before amp_nenable goes high on shutdown
MAX_RETRY, 2, NACK retries per entry before FAULT

Ports:
clk  in  1  system clock
resetb  in  1  asynchronous active-low reset
amp_en_cfg  in  1  sys_cfg amplifier enable (level)
soft_mute_cfg  in  1  sys_cfg soft mute (level)
audio_valid  in  1  SPDIF lock / I2S stream valid
m_req  out  1  write request to I2C master
m_dev_addr  out  7  device address (DEV_ADDR)
m_reg_addr  out  8  amplifier register address
m_wdata  out  8  data byte
m_ack  in  1  1-cycle pulse: write done, slave ACKed
m_nack  in  1  1-cycle pulse: write done, slave NACKed
amp_nenable  out  1  amplifier enable, active low
amp_mute  out  1  amplifier mute, active high
err_flag  out  1  sticky init failure
state_mon  out  3  current state encoding, for the register bank

Behaviour:
- All outputs registered. Reset: state OFF, amp_nenable=1, amp_mute=1, m_req=0, m_reg_addr/m_wdata=0, err_flag=0, index/retry/counter=0.
- States: OFF, PWRUP, INIT_WR, READY, UNMUTE_WAIT, PLAY, SHUTDOWN, FAULT.
- OFF: nenable=1, mute=1. On amp_en_cfg=1: go to PWRUP, nenable=0, load counter=T_PWRUP_CYC-1, clear err_flag.
- PWRUP: count down. At 0: go to INIT_WR with idx=0, retry=0.
- INIT_WR: m_req=1 with table[idx]. Address and data must stay stable while m_req=1.
  - On m_ack: m_req drops the next cycle. If idx==NUM_INIT-1, go to READY; otherwise idx++ and reassert after one idle cycle with m_req=0.
  - On m_nack: if retry<MAX_RETRY, retry++ and reissue the same idx after one idle cycle. Otherwise go to FAULT with err_flag=1.
  - If m_ack and m_nack arrive in the same cycle, treat it as nack.
  - m_ack/m_nack while m_req=0 are ignored.
- READY: mute=1. If audio_valid=1 and soft_mute_cfg=0: go to UNMUTE_WAIT, counter=T_UNMUTE_CYC-1.
- UNMUTE_WAIT: if audio_valid drops or soft_mute_cfg=1, return to READY. At counter 0: go to PLAY with mute=0.
- PLAY: mute=0. If audio_valid=0 or soft_mute_cfg=1: mute=1 on the next edge and go to READY.
- amp_en_cfg=0:
  - From PWRUP/READY/UNMUTE_WAIT/PLAY: mute=1 on the next edge, go to SHUTDOWN, counter=T_MUTE_CYC-1.
  - From INIT_WR: finish the outstanding transaction (wait for ack/nack), then go to SHUTDOWN. No further entries are issued.
- SHUTDOWN: at counter 0, go to OFF and set nenable=1. Re-enable during SHUTDOWN is ignored until OFF is reached.
- FAULT: nenable=1, mute=1, m_req=0. Leaves only on amp_en_cfg=0, going to OFF; err_flag stays set until the next PWRUP.
- Counter width: $clog2 of the maximum T_* parameter. Counters load N-1, so each wait lasts exactly N cycles.
- Reset mid-transaction: m_req drops immediately. The master must tolerate request withdrawal.
- Invariant: amp_mute=1 whenever amp_nenable toggles, in either direction.

Decomposition:
- Package toi2s_pkg:
  - amp_seq_state_t enum (3-bit; encoding fixed for state_mon: OFF=0 … FAULT=7)
  - amp_init_entry_t struct {reg_addr[7:0], data[7:0]}
  - AMP_INIT_TABLE constant array
  - rb_sys_cfg_wire_t gains the amp_en, soft_mute, amp_err and amp_state fields
- No sub-module inside. The bit-level amp_i2c_master, which drives amp_i2c_scl/amp_i2c_sda, is a separate sibling instantiated in toi2s_tt_fpga.

Test Plan:
All scenarios use T_PWRUP=10, T_UNMUTE=8, T_MUTE=4, NUM_INIT=3, MAX_RETRY=2, with the master model acking 5 cycles after req.
1. Reset, then amp_en_cfg=1 -> nenable=0 next edge; first m_req exactly 10 cycles later; 3 writes match the table; READY with mute=1.
2. READY, audio_valid=1 held -> mute=0 after 8 cycles; glitch audio_valid low at cycle 5 -> stays muted, the 8-cycle count restarts.
3. PLAY, amp_en_cfg=0 -> mute=1 next edge; nenable=1 exactly 4 cycles later; state_mon=OFF.
4. nack entry 1 twice, then ack -> 3 issues of entry 1, READY reached, err_flag=0; nack 3 times -> FAULT, err_flag=1, nenable=1.
5. amp_en_cfg=0 while m_req high -> m_req held until ack; no entry 2 issued; SHUTDOWN then OFF.
6. Simultaneous m_ack and m_nack on entry 0 -> counted as retry; spurious m_ack in READY -> no effect.
